// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch definitions: next-PC select encodings, fetch FSM states, default reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pc_unit_pkg;

  // EX-stage next-PC decision, also produced by the branch-decision logic
  typedef enum logic [1:0] {
    PCSEL_PLUS4  = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_JAL    = 2'b10,
    PCSEL_JALR   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_HALT     = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Any select other than sequential PC+4 redirects the fetch stream
  function automatic logic is_redirect(input logic [1:0] sel);
    return sel != PCSEL_PLUS4;
  endfunction

endpackage

// File: rtl/next_pc_target.sv
// Forms the redirect target from the EX-stage select and checks word alignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module next_pc_target
  import fetch_pc_unit_pkg::*;
(
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_branch_target,
  input  logic [31:0] i_jalr_target,
  output logic [31:0] o_target,
  output logic        o_redirect,
  output logic        o_misaligned
);

  // JALR clears bit 0 of rs1+imm before use
  logic [31:0] w_jalr_target;
  assign w_jalr_target = i_jalr_target & 32'hFFFF_FFFE;

  // Pick the target; branch and JAL share the EX-computed PC+imm
  always_comb begin
    o_target = i_branch_target;
    if (pc_sel_e'(i_pc_sel) == PCSEL_JALR) begin
      o_target = w_jalr_target;
    end
  end

  assign o_redirect   = is_redirect(i_pc_sel);
  // Only meaningful when redirecting; sequential PC is always aligned
  assign o_misaligned = o_redirect & (|o_target[1:0]);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and request FSM with one-entry pending redirect and sticky misalign trap.
// Latency: pc updates one cycle after the deciding inputs; flushes/fetchValid are same-cycle.
// Backpressure: imemReady=0 holds pc (WAIT_MEM); stall holds pc; HALT drops imemReq until reset.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcSel,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jalrTarget,
  input  logic        stall,
  input  logic        imemReady,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        imemReq,
  output logic        fetchValid,
  output logic        flushIFID,
  output logic        flushIDEX,
  output logic        misalignTrap
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_pc;
  logic         r_pend_vld;
  logic         r_trap;

  logic [31:0]  w_target;
  logic         w_redirect;
  logic         w_misaligned;
  logic         w_active;
  logic [31:0]  w_pc_plus4;
  logic         w_fetch_valid;
  logic         w_flush;

  next_pc_target u_next_pc_target (
    .i_pc_sel        (pcSel),
    .i_branch_target (branchTarget),
    .i_jalr_target   (jalrTarget),
    .o_target        (w_target),
    .o_redirect      (w_redirect),
    .o_misaligned    (w_misaligned)
  );

  assign w_active   = (r_state != ST_HALT);
  assign w_pc_plus4 = r_pc + 32'd4;   // wraps naturally at 2^32

  // Same-cycle control: flush on any redirect, deliver only clean completed fetches
  always_comb begin
    w_fetch_valid = 1'b0;
    w_flush       = 1'b0;
    if (w_active) begin
      if (w_redirect) begin
        w_flush = 1'b1;
      end else if (imemReady && !r_pend_vld && !stall) begin
        w_fetch_valid = 1'b1;
      end
    end
  end

  // FSM, pc register and pending redirect; newest redirect always overwrites pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_pend_vld <= 1'b0;
      r_trap     <= 1'b0;
    end else if (w_active) begin
      if (w_redirect && w_misaligned) begin
        r_state <= ST_HALT;
        r_trap  <= 1'b1;
      end else if (w_redirect) begin
        if (imemReady) begin
          // request completes now; its instruction is dropped by the flush
          r_pc       <= w_target;
          r_pend_vld <= 1'b0;
          r_state    <= ST_RUN;
        end else begin
          r_pend_pc  <= w_target;
          r_pend_vld <= 1'b1;
          r_state    <= ST_WAIT_MEM;
        end
      end else if (imemReady) begin
        r_state <= ST_RUN;
        if (r_pend_vld) begin
          r_pc       <= r_pend_pc;
          r_pend_vld <= 1'b0;
        end else if (!stall) begin
          r_pc <= w_pc_plus4;
        end
      end else begin
        r_state <= ST_WAIT_MEM;
      end
    end
  end

  assign pc           = r_pc;
  assign pcPlus4      = w_pc_plus4;
  assign imemReq      = w_active;
  assign fetchValid   = w_fetch_valid;
  assign flushIFID    = w_flush;
  assign flushIDEX    = w_flush;
  assign misalignTrap = r_trap;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  pcSel;
  logic [31:0] branchTarget;
  logic [31:0] jalrTarget;
  logic        stall;
  logic        imemReady;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        imemReq;
  logic        fetchValid;
  logic        flushIFID;
  logic        flushIDEX;
  logic        misalignTrap;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcSel        (pcSel),
    .branchTarget (branchTarget),
    .jalrTarget   (jalrTarget),
    .stall        (stall),
    .imemReady    (imemReady),
    .pc           (pc),
    .pcPlus4      (pcPlus4),
    .imemReq      (imemReq),
    .fetchValid   (fetchValid),
    .flushIFID    (flushIFID),
    .flushIDEX    (flushIDEX),
    .misalignTrap (misalignTrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        req;
    logic        fv;
    logic        fi;
    logic        fx;
    logic        trap;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec  = 0;
  int  n_fail = 0;

  // Drive one cycle of inputs just after the edge and queue its expected outputs
  task automatic step(input string nm, input logic r, input logic [1:0] sel,
                      input logic [31:0] bt, input logic [31:0] jt,
                      input logic st, input logic rdy,
                      input logic [31:0] epc, input logic efv, input logic efl,
                      input logic etrap, input logic ereq);
    sb_t e;
    @(posedge clk);
    #1;
    rst = r; pcSel = sel; branchTarget = bt; jalrTarget = jt;
    stall = st; imemReady = rdy;
    e.name     = nm;
    e.exp.pc   = epc;
    e.exp.pcp4 = epc + 32'd4;
    e.exp.req  = ereq;
    e.exp.fv   = efv;
    e.exp.fi   = efl;
    e.exp.fx   = efl;
    e.exp.trap = etrap;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs at the falling edge against the oldest expectation
  initial begin
    sb_t  e;
    obs_t got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = '{pc, pcPlus4, imemReq, fetchValid, flushIFID, flushIDEX, misalignTrap};
        n_vec++;
        if (got !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got pc=%h p4=%h req=%b fv=%b fi=%b fx=%b trap=%b, want pc=%h p4=%h req=%b fv=%b fi=%b fx=%b trap=%b",
                   e.name, got.pc, got.pcp4, got.req, got.fv, got.fi, got.fx, got.trap,
                   e.exp.pc, e.exp.pcp4, e.exp.req, e.exp.fv, e.exp.fi, e.exp.fx, e.exp.trap);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pcSel = 2'b00; branchTarget = '0; jalrTarget = '0;
    stall = 1'b0; imemReady = 1'b0;

    //   name          rst sel    branchTgt       jalrTgt   stall rdy  exp pc          fv fl trap req
    step("reset",      1, 2'b00, 32'h0,          32'h0,     0, 0, 32'h0000_0000, 0, 0, 0, 1);
    step("seq0",       0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0000, 1, 0, 0, 1);
    step("seq4",       0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0004, 1, 0, 0, 1);
    step("seq8",       0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0008, 1, 0, 0, 1);
    step("seq12",      0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_000C, 1, 0, 0, 1);
    step("br_to40",    0, 2'b01, 32'h40,         32'h0,     0, 1, 32'h0000_0010, 0, 1, 0, 1);
    step("br_stall",   0, 2'b01, 32'h100,        32'h0,     1, 1, 32'h0000_0040, 0, 1, 0, 1);
    step("stall_hold", 0, 2'b00, 32'h0,          32'h0,     1, 1, 32'h0000_0100, 0, 0, 0, 1);
    step("unstall",    0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0100, 1, 0, 0, 1);
    step("jalr_to20",  0, 2'b11, 32'h0,          32'h21,    0, 1, 32'h0000_0104, 0, 1, 0, 1);
    step("wait1",      0, 2'b00, 32'h0,          32'h0,     0, 0, 32'h0000_0020, 0, 0, 0, 1);
    step("wait_jalr",  0, 2'b11, 32'h0,          32'h205,   0, 0, 32'h0000_0020, 0, 1, 0, 1);
    step("wait3",      0, 2'b00, 32'h0,          32'h0,     0, 0, 32'h0000_0020, 0, 0, 0, 1);
    step("pend_drop",  0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0020, 0, 0, 0, 1);
    step("pend_pc",    0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0204, 1, 0, 0, 1);
    step("pend_a",     0, 2'b01, 32'h300,        32'h0,     0, 0, 32'h0000_0208, 0, 1, 0, 1);
    step("pend_b",     0, 2'b10, 32'h400,        32'h0,     0, 0, 32'h0000_0208, 0, 1, 0, 1);
    step("pend_b_drop",0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0208, 0, 0, 0, 1);
    step("newest_win", 0, 2'b00, 32'h0,          32'h0,     1, 1, 32'h0000_0400, 0, 0, 0, 1);
    step("wait_again", 0, 2'b00, 32'h0,          32'h0,     0, 0, 32'h0000_0400, 0, 0, 0, 1);
    step("wait_br_rdy",0, 2'b01, 32'h500,        32'h0,     0, 1, 32'h0000_0400, 0, 1, 0, 1);
    step("jal_top",    0, 2'b10, 32'hFFFF_FFFC,  32'h0,     0, 1, 32'h0000_0500, 0, 1, 0, 1);
    step("at_top",     0, 2'b00, 32'h0,          32'h0,     0, 1, 32'hFFFF_FFFC, 1, 0, 0, 1);
    step("wrapped",    0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0000, 1, 0, 0, 1);
    step("pend_rst_a", 0, 2'b01, 32'h800,        32'h0,     0, 0, 32'h0000_0004, 0, 1, 0, 1);
    step("rst_in_wait",1, 2'b00, 32'h0,          32'h0,     0, 0, 32'h0000_0004, 0, 0, 0, 1);
    step("post_rst0",  0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0000, 1, 0, 0, 1);
    step("no_stale",   0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0004, 1, 0, 0, 1);
    step("jal_misal",  0, 2'b10, 32'h102,        32'h0,     0, 1, 32'h0000_0008, 0, 1, 0, 1);
    step("halted",     0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0008, 0, 0, 1, 0);
    step("halt_ignore",0, 2'b01, 32'h40,         32'h0,     0, 1, 32'h0000_0008, 0, 0, 1, 0);
    step("halt_rst",   1, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0008, 0, 0, 1, 0);
    step("after_halt", 0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0000, 1, 0, 0, 1);
    step("jalr_misal", 0, 2'b11, 32'h0,          32'h6,     0, 0, 32'h0000_0004, 0, 1, 0, 1);
    step("halted2",    0, 2'b00, 32'h0,          32'h0,     0, 1, 32'h0000_0004, 0, 0, 1, 0);
    step("halt2_rst",  1, 2'b00, 32'h0,          32'h0,     0, 0, 32'h0000_0004, 0, 0, 1, 0);
    step("after_rst2", 0, 2'b00, 32'h0,          32'h0,     0, 0, 32'h0000_0000, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
